// File: rtl/sic4_sequencer_if.sv
// Control bundle between the SIC-4 sequencer and its datapath:
// fetched instruction in, PC/register-file/memory strobes and mux selects out.
interface sic4_sequencer_if;
  logic [7:0] instr;
  logic       pc_en;
  logic [7:0] ir_out;
  logic       reg_write;
  logic       mem_write;
  logic       use_imm;
  logic       use_load;
  logic [1:0] aluop;

  modport master (
    input  instr,
    output pc_en, ir_out, reg_write, mem_write, use_imm, use_load, aluop
  );

  modport slave (
    output instr,
    input  pc_en, ir_out, reg_write, mem_write, use_imm, use_load, aluop
  );
endinterface

// File: rtl/sic4_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer for the SIC-4 datapath.
// Optional performance counters are built when SIC4_SEQ_PERF_EN is defined.
module sic4_sequencer #(
  parameter logic [7:0] HALT_INSTR = 8'hFF,
  parameter int         CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  sic4_sequencer_if.master bus,
  input  logic             start,
  input  logic             step,
  input  logic             halt_req,
  output logic [2:0]       state,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALTED    = 3'd6
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic       run_q, run_d;
  logic       pend_q, pend_d;
  logic       boundary;
  logic       decoded;
  logic [1:0] op;

  assign op = ir_q[7:6];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ir_q    <= 8'h00;
      run_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      run_q   <= run_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    run_d    = run_q;
    pend_d   = pend_q;
    boundary = 1'b0;
    case (state_q)
      S_IDLE: begin
        run_d  = 1'b0;
        pend_d = 1'b0;
        if (start) begin
          run_d   = 1'b1;
          state_d = S_FETCH;
        end else if (step) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d    = bus.instr;
        state_d = S_DECODE;
      end
      S_DECODE:    state_d = (ir_q == HALT_INSTR) ? S_HALTED : S_EXECUTE;
      S_EXECUTE:   state_d = op[1] ? S_MEM : S_WRITEBACK;
      S_MEM: begin
        if (op == 2'b10) state_d = S_WRITEBACK;
        else             boundary = 1'b1;
      end
      S_WRITEBACK: boundary = 1'b1;
      S_HALTED:    state_d = S_HALTED;
      default:     state_d = S_IDLE;
    endcase
    // A halt or start seen in the boundary cycle itself already counts for that boundary.
    if (busy) begin
      if (halt_req) pend_d = 1'b1;
      if (start)    run_d  = 1'b1;
    end
    if (boundary) begin
      if (run_d && !pend_d) begin
        state_d = S_FETCH;
      end else begin
        state_d = S_IDLE;
        run_d   = 1'b0;
        pend_d  = 1'b0;
      end
    end
  end

  // Decoded selects are only meaningful once ir_out holds the current instruction.
  assign decoded = (state_q == S_DECODE) || (state_q == S_EXECUTE) ||
                   (state_q == S_MEM)    || (state_q == S_WRITEBACK);

  assign bus.ir_out    = ir_q;
  assign bus.pc_en     = boundary;
  assign bus.reg_write = (state_q == S_WRITEBACK);
  assign bus.mem_write = (state_q == S_MEM) && (op == 2'b11);
  assign bus.use_imm   = decoded && (op != 2'b00);
  assign bus.use_load  = decoded && (op == 2'b10);
  assign bus.aluop     = (decoded && (op == 2'b00)) ? ir_q[1:0] : 2'b00;

  assign state  = state_q;
  assign busy   = decoded || (state_q == S_FETCH);
  assign halted = (state_q == S_HALTED);

`ifdef SIC4_SEQ_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  logic [CNT_W-1:0] icnt_q, ccnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icnt_q <= '0;
      ccnt_q <= '0;
    end else begin
      if (boundary) icnt_q <= icnt_q + CNT_ONE;
      if (busy)     ccnt_q <= ccnt_q + CNT_ONE;
    end
  end

  assign instr_count = icnt_q;
  assign cycle_count = ccnt_q;
`else
  assign instr_count = '0;
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_sic4_sequencer.sv
// Directed bench for sic4_sequencer: inputs change and outputs are checked on the falling edge.
module tb_sic4_sequencer;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             step;
  logic             halt_req;
  logic [2:0]       state;
  logic             busy;
  logic             halted;
  logic [CNT_W-1:0] instr_count;
  logic [CNT_W-1:0] cycle_count;
  int               n_cmp;
  int               n_err;

  sic4_sequencer_if bus ();

  sic4_sequencer #(.HALT_INSTR(8'hFF), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.master),
    .start       (start),
    .step        (step),
    .halt_req    (halt_req),
    .state       (state),
    .busy        (busy),
    .halted      (halted),
    .instr_count (instr_count),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ctrl(input string tag, input logic [2:0] st, input logic pe, input logic rw,
                      input logic mw, input logic ui, input logic ul, input logic [1:0] aop);
    chk({tag, ".state"},     {29'd0, state},        {29'd0, st});
    chk({tag, ".pc_en"},     {31'd0, bus.pc_en},     {31'd0, pe});
    chk({tag, ".reg_write"}, {31'd0, bus.reg_write}, {31'd0, rw});
    chk({tag, ".mem_write"}, {31'd0, bus.mem_write}, {31'd0, mw});
    chk({tag, ".use_imm"},   {31'd0, bus.use_imm},   {31'd0, ui});
    chk({tag, ".use_load"},  {31'd0, bus.use_load},  {31'd0, ul});
    chk({tag, ".aluop"},     {30'd0, bus.aluop},     {30'd0, aop});
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; step = 1'b0; halt_req = 1'b0; bus.instr = 8'h00;
    tick(); tick();

    // Reset state
    ctrl("rst", 3'd0, 0, 0, 0, 0, 0, 2'd0);
    chk("rst.ir_out", {24'd0, bus.ir_out}, 32'h0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.halted", {31'd0, halted}, 32'd0);
    chk("rst.instr_count", {16'd0, instr_count}, 32'd0);
    chk("rst.cycle_count", {16'd0, cycle_count}, 32'd0);
    rst_n = 1'b1;

    // Three R-type instructions in free run, halt requested during the third
    bus.instr = 8'h16; start = 1'b1;
    tick(); start = 1'b0;
    chk("perf.fetch", {29'd0, state}, 32'd1);
    repeat (9) tick();
    halt_req = 1'b1;
    tick(); halt_req = 1'b0;
    chk("perf.exec3", {29'd0, state}, 32'd3);
    tick();
    chk("perf.wb3", {29'd0, state}, 32'd5);
    chk("perf.wb3_pc_en", {31'd0, bus.pc_en}, 32'd1);
    tick();
    chk("perf.idle", {29'd0, state}, 32'd0);
`ifdef SIC4_SEQ_PERF_EN
    chk("perf.instr_count", {16'd0, instr_count}, 32'd3);
    chk("perf.cycle_count", {16'd0, cycle_count}, 32'd12);
`else
    chk("perf.instr_count", {16'd0, instr_count}, 32'd0);
    chk("perf.cycle_count", {16'd0, cycle_count}, 32'd0);
`endif

    // Single step of R-type 8'h16
    step = 1'b1;
    tick(); step = 1'b0;
    ctrl("step.fetch", 3'd1, 0, 0, 0, 0, 0, 2'd0);
    chk("step.busy", {31'd0, busy}, 32'd1);
    tick();
    ctrl("step.decode", 3'd2, 0, 0, 0, 0, 0, 2'd2);
    chk("step.ir_out", {24'd0, bus.ir_out}, 32'h16);
    tick();
    ctrl("step.exec", 3'd3, 0, 0, 0, 0, 0, 2'd2);
    tick();
    ctrl("step.wb", 3'd5, 1, 1, 0, 0, 0, 2'd2);
    tick();
    ctrl("step.idle", 3'd0, 0, 0, 0, 0, 0, 2'd0);
    chk("step.busy_low", {31'd0, busy}, 32'd0);

    // Load 8'h85 then store 8'hC4 in free run
    bus.instr = 8'h85; start = 1'b1;
    tick(); start = 1'b0;
    ctrl("ld.fetch", 3'd1, 0, 0, 0, 0, 0, 2'd0);
    tick();
    ctrl("ld.decode", 3'd2, 0, 0, 0, 1, 1, 2'd0);
    chk("ld.ir_out", {24'd0, bus.ir_out}, 32'h85);
    tick();
    ctrl("ld.exec", 3'd3, 0, 0, 0, 1, 1, 2'd0);
    tick();
    ctrl("ld.mem", 3'd4, 0, 0, 0, 1, 1, 2'd0);
    tick();
    ctrl("ld.wb", 3'd5, 1, 1, 0, 1, 1, 2'd0);
    bus.instr = 8'hC4;
    tick();
    ctrl("st.fetch", 3'd1, 0, 0, 0, 0, 0, 2'd0);
    tick();
    ctrl("st.decode", 3'd2, 0, 0, 0, 1, 0, 2'd0);
    chk("st.ir_out", {24'd0, bus.ir_out}, 32'hC4);
    tick();
    ctrl("st.exec", 3'd3, 0, 0, 0, 1, 0, 2'd0);
    halt_req = 1'b1;
    tick(); halt_req = 1'b0;
    ctrl("st.mem", 3'd4, 1, 0, 1, 1, 0, 2'd0);
    tick();
    ctrl("st.idle", 3'd0, 0, 0, 0, 0, 0, 2'd0);

    // Halt request during EXECUTE of addi 8'h45
    bus.instr = 8'h45; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    tick();
    chk("addi.exec", {29'd0, state}, 32'd3);
    halt_req = 1'b1;
    tick(); halt_req = 1'b0;
    ctrl("addi.wb", 3'd5, 1, 1, 0, 1, 0, 2'd0);
    tick();
    chk("addi.idle", {29'd0, state}, 32'd0);
    repeat (5) tick();
    chk("addi.stay_idle", {29'd0, state}, 32'd0);
    chk("addi.not_busy", {31'd0, busy}, 32'd0);

    // HALT_INSTR reached in free run
    bus.instr = 8'hFF; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    chk("halt.decode", {29'd0, state}, 32'd2);
    tick();
    chk("halt.state", {29'd0, state}, 32'd6);
    chk("halt.halted", {31'd0, halted}, 32'd1);
    chk("halt.busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      start = (i % 2 == 0);
      step  = (i % 2 == 1);
      tick();
      ctrl("halt.hold", 3'd6, 0, 0, 0, 0, 0, 2'd0);
      chk("halt.hold_halted", {31'd0, halted}, 32'd1);
    end
    start = 1'b0; step = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("halt.reset_exit", {29'd0, state}, 32'd0);
    chk("halt.reset_halted", {31'd0, halted}, 32'd0);
    rst_n = 1'b1;

    // Asynchronous reset in MEM of a store
    bus.instr = 8'hC4; start = 1'b1;
    tick(); start = 1'b0;
    repeat (3) tick();
    chk("arst.mem", {29'd0, state}, 32'd4);
    chk("arst.mem_write_pre", {31'd0, bus.mem_write}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.state", {29'd0, state}, 32'd0);
    chk("arst.mem_write", {31'd0, bus.mem_write}, 32'd0);
    chk("arst.pc_en", {31'd0, bus.pc_en}, 32'd0);
    chk("arst.ir_out", {24'd0, bus.ir_out}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sic4_sequencer.md
Name: sic4_sequencer

Overview:
- Multi-cycle control sequencer for the SIC-4 8-bit datapath. It replaces the single-cycle combinational control unit and the free-running PC.
- Registers the fetched instruction, steps it through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and gates the PC, register-file and data-memory write strobes per phase.
- Provides run/step/halt debug control and optional retired-instruction and cycle counters.

Parameters:
- HALT_INSTR, 8'hFF, reserved encoding that stops the machine (enters HALTED, PC not advanced).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  8  instruction memory data at the current PC; fields op=[7:6], rtd=[5:4], rs=[3:2], fun_imm=[1:0].
- start  in  1  one-cycle pulse: begin free-running execution.
- step  in  1  one-cycle pulse: execute exactly one instruction.
- halt_req  in  1  request stop at the next instruction boundary.
- pc_en  out  1  PC increments on this cycle's rising edge.
- ir_out  out  8  registered instruction.
- reg_write  out  1  register-file write enable.
- mem_write  out  1  data-memory write enable.
- use_imm  out  1  ALU B-operand mux select (1 = zero-extended fun_imm).
- use_load  out  1  writeback mux select (1 = data memory).
- aluop  out  2  ALU operation.
- state  out  3  current state encoding.
- busy  out  1  high in FETCH..WRITEBACK.
- halted  out  1  high in HALTED.
- instr_count  out  CNT_W  retired instructions (optional).
- cycle_count  out  CNT_W  busy cycles (optional).

Behaviour:
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, HALTED=6.
- Reset (async, rst_n=0): state=IDLE, ir_out=8'h00, run flag=0, pending-halt flag=0, counters=0. All strobes and selects 0.
- IDLE:
  - start=1 -> set run, go to FETCH.
  - else step=1 -> clear run, go to FETCH.
  - start wins if both are asserted.
- FETCH: ir_out<=instr. Go to DECODE.
- DECODE: if ir_out==HALT_INSTR -> HALTED; else -> EXECUTE.
- EXECUTE: next state is MEM for op=10 (load) and op=11 (store), else WRITEBACK.
- MEM: op=10 -> WRITEBACK. op=11 -> instruction boundary.
- WRITEBACK: instruction boundary.
- Instruction boundary:
  - next state is FETCH if run=1 and no pending halt, otherwise IDLE.
  - reaching IDLE clears run and the pending-halt flag.
- Decoded controls are Moore functions of state and ir_out; they are 0 in IDLE, FETCH and HALTED.
  - op=00 R-type: aluop=fun_imm, use_imm=0.
  - op=01 addi, op=10 load, op=11 store: aluop=00 (add), use_imm=1.
  - use_load=1 only for op=10.
- Strobe timing:
  - reg_write=1 only in WRITEBACK.
  - mem_write=1 only in MEM with op=11.
  - pc_en=1 only in the boundary cycle: WRITEBACK, or MEM for a store.
- Latency: R-type/addi 4 cycles, load 5, store 4.
- halt_req:
  - Sampled every cycle while busy; sets the pending-halt flag.
  - Takes effect at the boundary; the current instruction always completes, including its write.
  - In IDLE, halt_req is ignored.
- step while busy is ignored. start while busy sets run (step converts to continuous run).
- HALTED: all strobes are 0, halted=1. start and step are ignored. Only rst_n exits.
- PC wraps 8'hFF->8'h00 in the PC block. The sequencer applies no wrap special case.

Optional Feature:
- Macro SIC4_SEQ_PERF_EN.
- Defined:
  - instr_count +1 (wrapping) on every pc_en cycle.
  - cycle_count +1 (wrapping) on every cycle with busy=1.
  - Both are cleared only by reset.
- Undefined: instr_count and cycle_count are tied to 0 and no counter flops are generated.

Test Plan:
- Reset, then step with instr=8'h16 (R-type, rtd=1, rs=1, funct=10) -> states 1,2,3,5,0. aluop=10 and reg_write=1 in WRITEBACK only; pc_en pulses once; busy low after 4 cycles.
- start with a load (8'h85) followed by a store (8'hC4) -> load takes 5 cycles with use_load=1 and reg_write in WRITEBACK. Store takes 4 cycles with mem_write=1 in MEM, reg_write never 1, pc_en in MEM.
- Free run, assert halt_req in EXECUTE of an addi -> addi writes back, pc_en=1, next state IDLE. No further FETCH until a new start.
- Free run reaching 8'hFF -> DECODE->HALTED. pc_en, reg_write and mem_write stay 0; start/step ignored for 10 cycles; halted=1 until rst_n.
- Drop rst_n in MEM of a store -> state=0 and mem_write=0 immediately (asynchronously); ir_out=8'h00.
- With SIC4_SEQ_PERF_EN, run 3 R-type instructions then halt -> instr_count=3, cycle_count=12. Without the macro, both read 0.
